// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: Moore-style control outputs with a
// zero-qualified PC write in BRANCH and a one-cycle illegal-opcode pulse.
module mips_multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic [2:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       i_or_d,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        I_EXEC    = 4'd10,
        I_WB      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    state_t state_q;
    state_t state_d;
    state_t dispatch;

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    // Opcode dispatch target out of DECODE; FETCH means unsupported.
    always_comb begin
        dispatch = FETCH;
        case (opcode)
            OP_RTYPE:                                  dispatch = R_EXEC;
            OP_LW, OP_SW:                              dispatch = MEM_ADDR;
            OP_BEQ, OP_BNE:                            dispatch = BRANCH;
            OP_J:                                      dispatch = JUMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_XORI: dispatch = I_EXEC;
            default:                                   dispatch = FETCH;
        endcase
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:     state_d = DECODE;
            DECODE:    state_d = dispatch;
            MEM_ADDR:  state_d = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  state_d = MEM_WB;
            R_EXEC:    state_d = R_WB;
            I_EXEC:    state_d = I_WB;
            default:   state_d = FETCH;
        endcase
    end

    always_comb begin
        alu_op     = 3'd4;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_source  = 2'b00;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        i_or_d     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            FETCH: begin
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
                ir_write  = 1'b1;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                illegal   = (dispatch == FETCH);
            end
            MEM_ADDR: begin
                alu_op    = 3'd1;
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEM_READ:  i_or_d = 1'b1;
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            R_EXEC: begin
                alu_op    = 3'd3;
                alu_src_a = 1'b1;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            // beq writes the PC on zero, bne on non-zero.
            BRANCH: begin
                alu_op    = 3'd2;
                alu_src_a = 1'b1;
                pc_source = 2'b01;
                pc_write  = (opcode == OP_BNE) ? ~zero : zero;
            end
            JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
            end
            I_EXEC: begin
                alu_op    = 3'd0;
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            I_WB:      reg_write = 1'b1;
            default:   ;
        endcase

        // Reset presents FETCH steering with every write enable held off.
        if (rst) begin
            alu_op     = 3'd4;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b01;
            pc_source  = 2'b00;
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            i_or_d     = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: a per-instruction model
// queues expected per-cycle outputs, a negedge monitor pops and compares.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write, ir_write, mem_write, reg_write;
    logic       i_or_d, reg_dst, mem_to_reg, illegal;
    logic [3:0] state;

    mips_multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_source(pc_source), .pc_write(pc_write), .ir_write(ir_write),
        .mem_write(mem_write), .reg_write(reg_write), .i_or_d(i_or_d),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] aop;
        logic       sa;
        logic [1:0] sb;
        logic [1:0] ps;
        logic       pw, iw, mw, rw, iod, rd, m2r, ill;
    } rec_t;

    rec_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Visited state codes for one instruction, straight from the dispatch rules.
    function automatic void path_for(input logic [5:0] op, output int p[$], output bit bad);
        bad = 1'b0;
        case (op)
            6'b100011:                               p = '{0, 1, 2, 3, 4};
            6'b101011:                               p = '{0, 1, 2, 5};
            6'b000000:                               p = '{0, 1, 6, 7};
            6'b001000, 6'b001100, 6'b001101,
            6'b001010, 6'b001110:                    p = '{0, 1, 10, 11};
            6'b000100, 6'b000101:                    p = '{0, 1, 8};
            6'b000010:                               p = '{0, 1, 9};
            default: begin
                p = '{0, 1};
                bad = 1'b1;
            end
        endcase
    endfunction

    function automatic rec_t outs_for(input int s, input logic [5:0] op, input logic z, input bit bad);
        rec_t r = '0;
        r.st  = 4'(s);
        r.aop = 3'd4;
        case (s)
            0:  begin r.sb = 2'b01; r.pw = 1; r.iw = 1; end
            1:  begin r.sb = 2'b11; r.ill = bad; end
            2:  begin r.aop = 3'd1; r.sa = 1; r.sb = 2'b10; end
            3:  r.iod = 1;
            4:  begin r.rw = 1; r.m2r = 1; end
            5:  begin r.iod = 1; r.mw = 1; end
            6:  begin r.aop = 3'd3; r.sa = 1; end
            7:  begin r.rw = 1; r.rd = 1; end
            8:  begin r.aop = 3'd2; r.sa = 1; r.ps = 2'b01; r.pw = (op == 6'b000100) ? z : !z; end
            9:  begin r.ps = 2'b10; r.pw = 1; end
            10: begin r.aop = 3'd0; r.sa = 1; r.sb = 2'b10; end
            11: r.rw = 1;
            default: ;
        endcase
        return r;
    endfunction

    function automatic rec_t reset_rec(input int s);
        rec_t r = '0;
        r.st  = 4'(s);
        r.aop = 3'd4;
        r.sb  = 2'b01;
        return r;
    endfunction

    // Called just after a rising edge; drives one instruction, optionally
    // holding rst high during its final cycle.
    task automatic run_instr(input logic [5:0] op, input logic z, input bit rst_last);
        int p[$];
        bit bad;
        path_for(op, p, bad);
        opcode = op;
        zero   = z;
        for (int i = 0; i < p.size(); i++) begin
            if (rst_last && i == p.size() - 1) exp_q.push_back(reset_rec(p[i]));
            else                               exp_q.push_back(outs_for(p[i], op, z, bad));
        end
        for (int i = 0; i < p.size(); i++) begin
            if (rst_last && i == p.size() - 1) rst = 1'b1;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        rec_t a, e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = '{state, alu_op, alu_src_a, alu_src_b, pc_source, pc_write, ir_write,
                  mem_write, reg_write, i_or_d, reg_dst, mem_to_reg, illegal};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL cycle_outputs t=%0t actual=%h required=%h (st=%0d/%0d)",
                         $time, a, e, a.st, e.st);
            end
        end
    end

    localparam logic [5:0] LEGAL [11] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                          6'b000101, 6'b000010, 6'b001000, 6'b001100,
                                          6'b001101, 6'b001010, 6'b001110};

    initial begin
        logic [5:0] op;
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(reset_rec(0));
        @(posedge clk); #1;
        exp_q.push_back(reset_rec(0));
        @(posedge clk); #1;
        rst = 1'b0;

        run_instr(6'b100011, 1'b0, 1'b0);
        run_instr(6'b101011, 1'b0, 1'b0);
        run_instr(6'b000100, 1'b1, 1'b0);
        run_instr(6'b000101, 1'b1, 1'b0);
        run_instr(6'b000100, 1'b0, 1'b0);
        run_instr(6'b000101, 1'b0, 1'b0);
        run_instr(6'b001101, 1'b0, 1'b0);
        run_instr(6'b000000, 1'b0, 1'b0);
        run_instr(6'b000010, 1'b0, 1'b0);
        run_instr(6'b111111, 1'b0, 1'b0);
        run_instr(6'b101011, 1'b0, 1'b1);
        run_instr(6'b100011, 1'b1, 1'b1);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) < 7) op = LEGAL[$urandom_range(0, 10)];
            else                          op = 6'($urandom);
            run_instr(op, 1'($urandom), ($urandom_range(0, 19) == 0));
        end

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clk);
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain actual=%0d required=0 entries left", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
